// File: rtl/gru_ht_update.sv
// -----------------------------------------------------------------------------
// gru_ht_update
//   Hidden-state update stage of a GRU hidden layer. It takes one (z, h~) pair
//   per cell, serially, and computes ht = ht1 + z*(h~ - ht1) in signed fixed
//   point. It holds the packed hidden vector ht1 that feeds back to the gate
//   units, and it sequences STEP time steps per sequence.
//
//   Optional feature: define GRU_HT_SAT_EN to saturate each result to the
//   signed DATABIT range. When the macro is undefined, results wrap in two's
//   complement.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous reset, active low
//   start     pulse: begin a new sequence with h0 = 0 (ignored unless idle)
//   in_valid  z_in / hc_in are valid for the current cell
//   in_ready  the stage accepts a pair this cycle (high only while collecting)
//   z_in      update gate z for the current cell (signed, FRAC fractional bits)
//   hc_in     candidate h~ for the current cell (signed, FRAC fractional bits)
//   ht1       current hidden vector; cell c is at [DATABIT*c +: DATABIT]
//   ht_valid  1-cycle pulse: ht1 has just been updated with a new time step
//   seq_done  1-cycle pulse, together with ht_valid, on the final step
//   busy      high whenever the stage is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gru_ht_update #(
  parameter int CELLNUM = 4,
  parameter int DATABIT = 16,
  parameter int FRAC    = 12,
  parameter int STEP    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATABIT-1:0]         z_in,
  input  logic [DATABIT-1:0]         hc_in,
  output logic [CELLNUM*DATABIT-1:0] ht1,
  output logic                       ht_valid,
  output logic                       seq_done,
  output logic                       busy
);

  localparam int CW = (CELLNUM > 1) ? $clog2(CELLNUM) : 1;
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  // Wide enough to hold h + (z*d >>> FRAC) without overflow.
  localparam int WW = 2*DATABIT + 2;

  localparam logic [CW-1:0] LAST_CELL = CW'(CELLNUM-1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEP-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CELLNUM-1:0][DATABIT-1:0] ht1_q;
  logic [CELLNUM-1:0][DATABIT-1:0] ht_next_q;
  logic [CW-1:0]                   cell_cnt_q;
  logic [SW-1:0]                   step_cnt_q;
  logic                            ht_valid_q;
  logic                            seq_done_q;
  logic                            accept;

  // ---------------------------------------------------------------------------
  // Per-cell arithmetic. The previous-step value of the cell being collected is
  // used; ht1 stays frozen for the whole collect phase.
  // ---------------------------------------------------------------------------
  logic signed [DATABIT-1:0] h_sel;
  logic signed [DATABIT-1:0] z_s;
  logic signed [DATABIT-1:0] hc_s;
  logic signed [DATABIT:0]   diff_w;
  logic signed [WW-1:0]      prod_w;
  logic signed [WW-1:0]      q_w;
  logic signed [WW-1:0]      s_w;
  logic signed [DATABIT-1:0] ht_calc;

  assign h_sel  = ht1_q[cell_cnt_q];
  assign z_s    = z_in;
  assign hc_s   = hc_in;
  assign diff_w = (DATABIT+1)'(hc_s) - (DATABIT+1)'(h_sel);
  assign prod_w = WW'(z_s) * WW'(diff_w);
  // Arithmetic shift: truncation toward minus infinity, no rounding.
  assign q_w    = prod_w >>> FRAC;
  assign s_w    = WW'(h_sel) + q_w;

`ifdef GRU_HT_SAT_EN
  // The result fits only if every bit from the DATABIT-1 sign position upward
  // is identical; otherwise clamp toward the sign of the wide sum.
  logic fits;
  assign fits    = (&s_w[WW-1:DATABIT-1]) | ~(|s_w[WW-1:DATABIT-1]);
  assign ht_calc = fits        ? DATABIT'(s_w) :
                   s_w[WW-1]   ? {1'b1, {(DATABIT-1){1'b0}}} :
                                 {1'b0, {(DATABIT-1){1'b1}}};
`else
  assign ht_calc = DATABIT'(s_w);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the simulator evaluates blocks.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (accept && (cell_cnt_q == LAST_CELL)) state_d = COMMIT;
      COMMIT:  state_d = (step_cnt_q == LAST_STEP) ? IDLE : COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (pure decode of the current state)
  always_comb begin
    in_ready = (state_q == COLLECT);
    busy     = (state_q != IDLE);
    accept   = in_valid & in_ready;
  end

  // ---------------------------------------------------------------------------
  // Datapath and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ht1_q      <= '0;
      // NOTE: the staging buffer is plain flops, not a RAM, so it is cleared
      // with the rest; a reset mid-step discards any partial results.
      ht_next_q  <= '0;
      cell_cnt_q <= '0;
      step_cnt_q <= '0;
      ht_valid_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      ht_valid_q <= 1'b0;
      seq_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ht1_q      <= '0;
            cell_cnt_q <= '0;
            step_cnt_q <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            ht_next_q[cell_cnt_q] <= ht_calc;
            cell_cnt_q <= (cell_cnt_q == LAST_CELL) ? '0 : cell_cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          ht1_q      <= ht_next_q;
          ht_valid_q <= 1'b1;
          if (step_cnt_q == LAST_STEP) begin
            seq_done_q <= 1'b1;
            step_cnt_q <= '0;
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ht1      = ht1_q;
  assign ht_valid = ht_valid_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_gru_ht_update.sv
// -----------------------------------------------------------------------------
// tb_gru_ht_update
//   Self-checking bench for gru_ht_update. The main instance (STEP=3) is driven
//   with directed and random (z, h~) pairs. An arithmetic reference model
//   computes each committed hidden vector and pushes it into a queue; a monitor
//   pops and compares whenever the DUT pulses ht_valid. A second instance with
//   STEP=10 is used to count pulses over full sequences.
//   Honours GRU_HT_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gru_ht_update;

  localparam int CELLNUM = 4;
  localparam int DATABIT = 16;
  localparam int FRAC    = 12;
  localparam int STEP    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z_in;
  logic [15:0] hc_in;
  logic [63:0] ht1;
  logic        ht_valid;
  logic        seq_done;
  logic        busy;

  logic        start10;
  logic        in_valid10;
  logic        in_ready10;
  logic [15:0] z10;
  logic [15:0] hc10;
  logic [63:0] ht1_10;
  logic        ht_valid10;
  logic        seq_done10;
  logic        busy10;

  always #5 clk = ~clk;

  gru_ht_update #(.CELLNUM(CELLNUM), .DATABIT(DATABIT), .FRAC(FRAC), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .z_in(z_in), .hc_in(hc_in), .ht1(ht1), .ht_valid(ht_valid), .seq_done(seq_done),
    .busy(busy)
  );

  gru_ht_update #(.CELLNUM(CELLNUM), .DATABIT(DATABIT), .FRAC(FRAC), .STEP(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .in_valid(in_valid10), .in_ready(in_ready10),
    .z_in(z10), .hc_in(hc10), .ht1(ht1_10), .ht_valid(ht_valid10), .seq_done(seq_done10),
    .busy(busy10)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the update formula
  // ---------------------------------------------------------------------------
  typedef struct { logic [63:0] ht; logic done; } exp_t;
  exp_t exp_q[$];

  int mh[CELLNUM];
  int mnext[CELLNUM];
  int mcell;
  int mstep;
  bit m_busy;

  function automatic int upd(int h, int z, int hc);
    longint p, q, s;
    p = longint'(z) * longint'(hc - h);
    // floor(p / 2^FRAC)
    if (p >= 0) q = p / 4096;
    else        q = -((-p + 4095) / 4096);
    s = longint'(h) + q;
`ifdef GRU_HT_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`else
    s = s & 64'hFFFF;
    if (s >= 32768) s = s - 65536;
`endif
    return int'(s);
  endfunction

  function automatic logic [63:0] pack_mh();
    logic [63:0] r;
    for (int c = 0; c < CELLNUM; c++) r[16*c +: 16] = 16'(mh[c]);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CELLNUM; c++) mh[c] = 0;
    mcell  = 0;
    mstep  = 0;
    m_busy = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [15:0] z, input logic [15:0] hc);
    exp_t e;
    mnext[mcell] = upd(mh[mcell], int'($signed(z)), int'($signed(hc)));
    mcell++;
    if (mcell == CELLNUM) begin
      mcell = 0;
      mh    = mnext;
      mstep++;
      e.done = (mstep == STEP);
      if (e.done) begin
        mstep  = 0;
        m_busy = 0;
      end
      e.ht = pack_mh();
      exp_q.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every ht_valid pulse against the scoreboard
  // ---------------------------------------------------------------------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && ht_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected ht_valid", 64'(ht_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb ht1", ht1, mon_e.ht);
        check("sb seq_done", 64'(seq_done), 64'(mon_e.done));
      end
    end else if (rst_n && seq_done) begin
      check("seq_done without ht_valid", 64'(seq_done), 64'd0);
    end
  end

  int cnt10 = 0;
  int done_at10 = 0;
  int ndone10 = 0;
  always @(negedge clk) begin
    if (rst_n && ht_valid10) begin
      cnt10++;
      if (seq_done10) begin
        ndone10++;
        done_at10 = cnt10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    if (!m_busy) begin
      for (int c = 0; c < CELLNUM; c++) mh[c] = 0;
      mcell  = 0;
      mstep  = 0;
      m_busy = 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] z, input logic [15:0] hc);
    int waited = 0;
    in_valid = 1'b1;
    z_in     = z;
    hc_in    = hc;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(z, hc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      z_in  = 16'($urandom);
      hc_in = 16'($urandom);
      @(negedge clk);
    end
  endtask

  // Called right after the final accept of a step: checks the commit result
  // one edge later, then returns at the following falling edge.
  task automatic commit_check(input string name, input logic [63:0] exp);
    @(posedge clk);
    #1;
    check({name, " ht_valid"}, 64'(ht_valid), 64'd1);
    check({name, " ht1"}, ht1, exp);
    @(negedge clk);
  endtask

  task automatic random_step(input bit gaps);
    for (int c = 0; c < CELLNUM; c++) begin
      if (gaps) gap($urandom_range(0, 2));
      send(16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    z_in       = '0;
    hc_in      = '0;
    start10    = 1'b0;
    in_valid10 = 1'b0;
    z10        = '0;
    hc10       = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset ht1", ht1, 64'd0);
    check("reset ht_valid", 64'(ht_valid), 64'd0);
    check("reset seq_done", 64'(seq_done), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: half-way blend from 0 toward 1.0, back-to-back
    pulse_start();
    check("T1 busy after start", 64'(busy), 64'd1);
    for (int c = 0; c < CELLNUM; c++) send(16'd2048, 16'd4096);
    check("T1 ht_valid low in COMMIT", 64'(ht_valid), 64'd0);
    check("T1 in_ready low in COMMIT", 64'(in_ready), 64'd0);
    commit_check("T1", {4{16'h0800}});

    // T2: full update toward -1.0, then z=0 keeps ht1, last step ends sequence
    for (int c = 0; c < CELLNUM; c++) send(16'd4096, 16'hF000);
    commit_check("T2a", {4{16'hF000}});
    for (int c = 0; c < CELLNUM; c++) send(16'd0, 16'd1234);
    @(posedge clk);
    #1;
    check("T2b seq_done", 64'(seq_done), 64'd1);
    check("T2b ht1 unchanged", ht1, {4{16'hF000}});
    @(negedge clk);
    check("T2 busy after final", 64'(busy), 64'd0);
    @(negedge clk);
    check("T2 ht_valid single pulse", 64'(ht_valid), 64'd0);

    // T3: random values with gaps; junk in_valid during COMMIT and IDLE
    pulse_start();
    for (int s = 0; s < STEP; s++) begin
      random_step(1'b1);
      in_valid = 1'b1;
      z_in     = 16'($urandom);
      hc_in    = 16'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
    end
    in_valid = 1'b1;
    repeat (5) begin
      z_in  = 16'($urandom);
      hc_in = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("T3 IDLE ignores in_valid", ht1, pack_mh());
    check("T3 idle busy", 64'(busy), 64'd0);

    // T4: overflow handling and floor rounding
    pulse_start();
    for (int c = 0; c < CELLNUM; c++) send(16'd2048, 16'd4096);
    @(negedge clk);
    send(16'd8192, 16'h7FFF);
    send(16'd8192, 16'h7FFF);
    send(16'd8192, 16'h8000);
    send(16'd4096, 16'd100);
`ifdef GRU_HT_SAT_EN
    commit_check("T4 overflow", {16'd100, 16'h8000, 16'h7FFF, 16'h7FFF});
`else
    commit_check("T4 overflow", {16'd100, 16'hF800, 16'hF7FE, 16'hF7FE});
`endif
    random_step(1'b0);
    repeat (2) @(negedge clk);
    pulse_start();
    for (int c = 0; c < CELLNUM; c++) send(16'd2048, 16'hFFFF);
    commit_check("T4 floor", {4{16'hFFFF}});
    random_step(1'b0);
    random_step(1'b1);
    repeat (3) @(negedge clk);

    // T5: start ignored mid-collect; async reset mid-collect; clean restart
    pulse_start();
    send(16'($urandom), 16'($urandom));
    send(16'($urandom), 16'($urandom));
    pulse_start();
    send(16'($urandom), 16'($urandom));
    send(16'($urandom), 16'($urandom));
    @(negedge clk);
    send(16'($urandom), 16'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    check("T5 async ht1", ht1, 64'd0);
    check("T5 async busy", 64'(busy), 64'd0);
    check("T5 async in_ready", 64'(in_ready), 64'd0);
    check("T5 async ht_valid", 64'(ht_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int c = 0; c < CELLNUM; c++) send(16'd2048, 16'd4096);
    commit_check("T5 clean step", {4{16'h0800}});
    random_step(1'b0);
    random_step(1'b0);
    repeat (3) @(negedge clk);

    // T6: ten-step instance, two full sequences
    for (int run = 0; run < 2; run++) begin
      cnt10     = 0;
      done_at10 = 0;
      ndone10   = 0;
      start10    = 1'b1;
      in_valid10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      repeat (70) begin
        z10  = 16'($urandom);
        hc10 = 16'($urandom);
        @(negedge clk);
      end
      check("T6 ht_valid count", 64'(cnt10), 64'd10);
      check("T6 seq_done count", 64'(ndone10), 64'd1);
      check("T6 seq_done on 10th", 64'(done_at10), 64'd10);
      check("T6 idle after seq", 64'(busy10), 64'd0);
    end
    in_valid10 = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
